// File: rtl/load_store_queue_if.sv
// Memory request bus between the load/store queue and the memory controller.
// The queue drives the request as master; the controller answers with ready.
interface load_store_queue_if #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
);
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_req_store;
  logic [OP_W-1:0]  mem_req_op;
  logic [XLEN-1:0]  mem_req_addr;
  logic [XLEN-1:0]  mem_req_wdata;
  logic [ROB_W-1:0] mem_req_id;

  modport master (
    output mem_req_valid,
    output mem_req_store,
    output mem_req_op,
    output mem_req_addr,
    output mem_req_wdata,
    output mem_req_id,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_store,
    input  mem_req_op,
    input  mem_req_addr,
    input  mem_req_wdata,
    input  mem_req_id,
    output mem_req_ready
  );
endinterface

// File: rtl/load_store_queue.sv
// In-order load/store queue: address generation, CDB wakeup and
// head-of-queue issue to memory over a registered valid/ready request.
module load_store_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 8,
  parameter int              ROB_W     = 4,
  parameter int              OP_W      = 6,
  parameter int              NUM_CDB   = 2,
  parameter logic [XLEN-1:0] MMIO_BASE = 'h30000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     io_full,
  input  logic                     disp_valid,
  input  logic                     disp_is_store,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [ROB_W-1:0]         disp_rob_id,
  input  logic [XLEN-1:0]          disp_imm,
  input  logic [ROB_W:0]           disp_q1,
  input  logic [XLEN-1:0]          disp_v1,
  input  logic [ROB_W:0]           disp_q2,
  input  logic [XLEN-1:0]          disp_v2,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  input  logic [ROB_W-1:0]         rob_head_id,
  load_store_queue_if.master       mem,
  output logic                     lsq_full,
  output logic                     lsq_empty,
  output logic [$clog2(DEPTH):0]   lsq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = ROB_W + 1;
  localparam logic [TW-1:0] NONE = '1;

  typedef struct packed {
    logic             is_store;
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] id;
    logic [XLEN-1:0]  addr;
    logic [TW-1:0]    q1;
    logic [TW-1:0]    q2;
    logic [XLEN-1:0]  v2;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  entry_t new_e;
  entry_t hd;
  logic   enq;
  logic   launch;
  logic   eligible;
  logic   at_head;
  logic   mmio;

  assign lsq_count = count_q;
  assign lsq_full  = count_q == CW'(DEPTH);
  assign lsq_empty = count_q == '0;

  // Walk channels high to low so the lowest matching index wins.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (vld_q[i] && cdb_valid[k]) begin
          if (ent_q[i].q1 == {1'b0, cdb_tag[k*ROB_W +: ROB_W]}) begin
            ent_d[i].q1   = NONE;
            ent_d[i].addr = ent_q[i].addr + cdb_data[k*XLEN +: XLEN];
          end
          if (ent_q[i].q2 == {1'b0, cdb_tag[k*ROB_W +: ROB_W]}) begin
            ent_d[i].q2 = NONE;
            ent_d[i].v2 = cdb_data[k*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    new_e.is_store = disp_is_store;
    new_e.op       = disp_op;
    new_e.id       = disp_rob_id;
    new_e.q1       = disp_q1;
    new_e.addr     = (disp_q1 == NONE) ? disp_v1 + disp_imm : disp_imm;
    new_e.q2       = disp_is_store ? disp_q2 : NONE;
    new_e.v2       = disp_v2;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k]) begin
        if (new_e.q1 != NONE &&
            disp_q1 == {1'b0, cdb_tag[k*ROB_W +: ROB_W]}) begin
          new_e.q1   = NONE;
          new_e.addr = cdb_data[k*XLEN +: XLEN] + disp_imm;
        end
        if (disp_is_store &&
            disp_q2 == {1'b0, cdb_tag[k*ROB_W +: ROB_W]}) begin
          new_e.q2 = NONE;
          new_e.v2 = cdb_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  assign hd      = ent_q[head_q];
  assign at_head = hd.id == rob_head_id;
  assign mmio    = hd.addr >= MMIO_BASE;

  always_comb begin
    eligible = 1'b0;
    if (!lsq_empty && hd.q1 == NONE) begin
      if (hd.is_store)
        eligible = (hd.q2 == NONE) && at_head;
      else if (mmio)
        eligible = at_head && !io_full;
      else
        eligible = 1'b1;
    end
  end

  assign enq    = disp_valid && !stall && !flush && !lsq_full;
  assign launch = eligible && !flush &&
                  (!mem.mem_req_valid || mem.mem_req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
      if (flush) begin
        vld_q   <= '0;
        tail_q  <= head_q;
        count_q <= '0;
      end else begin
        if (enq) begin
          ent_q[tail_q] <= new_e;
          vld_q[tail_q] <= 1'b1;
          tail_q        <= tail_q + PW'(1);
        end
        if (launch) begin
          vld_q[head_q] <= 1'b0;
          head_q        <= head_q + PW'(1);
        end
        count_q <= count_q + CW'(enq) - CW'(launch);
      end
    end
  end

  // A committed store in flight survives a flush; a load does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_store <= 1'b0;
      mem.mem_req_op    <= '0;
      mem.mem_req_addr  <= '0;
      mem.mem_req_wdata <= '0;
      mem.mem_req_id    <= '0;
    end else if (flush) begin
      if (!(mem.mem_req_valid && mem.mem_req_store) || mem.mem_req_ready)
        mem.mem_req_valid <= 1'b0;
    end else if (launch) begin
      mem.mem_req_valid <= 1'b1;
      mem.mem_req_store <= hd.is_store;
      mem.mem_req_op    <= hd.op;
      mem.mem_req_addr  <= hd.addr;
      mem.mem_req_wdata <= hd.is_store ? hd.v2 : '0;
      mem.mem_req_id    <= hd.id;
    end else if (mem.mem_req_ready) begin
      mem.mem_req_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: issue, wakeup, MMIO gating,
// fill/drain with wrap, hold under backpressure, flush and reset.
module tb_load_store_queue;

  localparam logic [4:0] NONE = 5'h1F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        io_full = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_is_store = 1'b0;
  logic [5:0]  disp_op = '0;
  logic [3:0]  disp_rob_id = '0;
  logic [31:0] disp_imm = '0;
  logic [4:0]  disp_q1 = NONE;
  logic [31:0] disp_v1 = '0;
  logic [4:0]  disp_q2 = NONE;
  logic [31:0] disp_v2 = '0;
  logic [1:0]  cdb_valid = '0;
  logic [7:0]  cdb_tag = '0;
  logic [63:0] cdb_data = '0;
  logic [3:0]  rob_head_id = '0;
  logic        lsq_full;
  logic        lsq_empty;
  logic [3:0]  lsq_count;

  int n_chk = 0;
  int n_fail = 0;

  load_store_queue_if #(.XLEN(32), .ROB_W(4), .OP_W(6)) mem ();

  load_store_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .stall         (stall),
    .io_full       (io_full),
    .disp_valid    (disp_valid),
    .disp_is_store (disp_is_store),
    .disp_op       (disp_op),
    .disp_rob_id   (disp_rob_id),
    .disp_imm      (disp_imm),
    .disp_q1       (disp_q1),
    .disp_v1       (disp_v1),
    .disp_q2       (disp_q2),
    .disp_v2       (disp_v2),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .rob_head_id   (rob_head_id),
    .mem           (mem.master),
    .lsq_full      (lsq_full),
    .lsq_empty     (lsq_empty),
    .lsq_count     (lsq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic st, input logic [5:0] op,
                     input logic [3:0] id, input logic [31:0] imm,
                     input logic [4:0] q1, input logic [31:0] v1,
                     input logic [4:0] q2, input logic [31:0] v2);
    disp_is_store = st;
    disp_op       = op;
    disp_rob_id   = id;
    disp_imm      = imm;
    disp_q1       = q1;
    disp_v1       = v1;
    disp_q2       = q2;
    disp_v2       = v2;
    disp_valid    = 1'b1;
    tick();
    disp_valid    = 1'b0;
  endtask

  task automatic bus(input logic [1:0] v, input logic [3:0] t0,
                     input logic [31:0] d0, input logic [3:0] t1,
                     input logic [31:0] d1);
    cdb_valid = v;
    cdb_tag   = {t1, t0};
    cdb_data  = {d1, d0};
  endtask

  initial begin
    mem.mem_req_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(mem.mem_req_valid), 32'd0);
    chk("rst_empty", 32'(lsq_empty), 32'd1);
    chk("rst_full",  32'(lsq_full), 32'd0);
    chk("rst_count", 32'(lsq_count), 32'd0);
    chk("rst_addr",  mem.mem_req_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // simple load, then hold under backpressure
    put(1'b0, 6'h03, 4'd1, 32'h4, NONE, 32'h100, NONE, 32'h0);
    chk("ld_enq_count", 32'(lsq_count), 32'd1);
    chk("ld_enq_valid", 32'(mem.mem_req_valid), 32'd0);
    tick();
    chk("ld_valid", 32'(mem.mem_req_valid), 32'd1);
    chk("ld_addr",  mem.mem_req_addr, 32'h104);
    chk("ld_wdata", mem.mem_req_wdata, 32'h0);
    chk("ld_store", 32'(mem.mem_req_store), 32'd0);
    chk("ld_id",    32'(mem.mem_req_id), 32'd1);
    chk("ld_op",    32'(mem.mem_req_op), 32'h3);
    chk("ld_pop",   32'(lsq_count), 32'd0);
    put(1'b0, 6'h05, 4'd2, 32'h10, NONE, 32'h200, NONE, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk("hold_addr",  mem.mem_req_addr, 32'h104);
      chk("hold_id",    32'(mem.mem_req_id), 32'd1);
      chk("hold_op",    32'(mem.mem_req_op), 32'h3);
      chk("hold_count", 32'(lsq_count), 32'd1);
      if (c < 2) tick();
    end
    mem.mem_req_ready = 1'b1;
    tick();
    chk("b2b_valid", 32'(mem.mem_req_valid), 32'd1);
    chk("b2b_addr",  mem.mem_req_addr, 32'h210);
    chk("b2b_id",    32'(mem.mem_req_id), 32'd2);
    chk("b2b_count", 32'(lsq_count), 32'd0);
    tick();
    chk("drop_valid", 32'(mem.mem_req_valid), 32'd0);

    // store waiting on two tags, both woken in one cycle
    put(1'b1, 6'h07, 4'd6, 32'h8, 5'd3, 32'hDEAD, 5'd5, 32'hBEEF);
    bus(2'b11, 4'd3, 32'h200, 4'd5, 32'hAB);
    tick();
    bus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    tick();
    chk("st_wait_valid", 32'(mem.mem_req_valid), 32'd0);
    chk("st_wait_count", 32'(lsq_count), 32'd1);
    rob_head_id = 4'd6;
    tick();
    chk("st_valid", 32'(mem.mem_req_valid), 32'd1);
    chk("st_store", 32'(mem.mem_req_store), 32'd1);
    chk("st_addr",  mem.mem_req_addr, 32'h208);
    chk("st_wdata", mem.mem_req_wdata, 32'hAB);
    chk("st_id",    32'(mem.mem_req_id), 32'd6);
    tick();
    chk("st_done", 32'(mem.mem_req_valid), 32'd0);
    rob_head_id = 4'd0;

    // both channels carry the same tag: channel 0 wins
    put(1'b0, 6'h01, 4'd7, 32'h1000, 5'd7, 32'h0, NONE, 32'h0);
    bus(2'b11, 4'd7, 32'h40, 4'd7, 32'h80);
    tick();
    bus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    tick();
    chk("prio_valid", 32'(mem.mem_req_valid), 32'd1);
    chk("prio_addr",  mem.mem_req_addr, 32'h1040);

    // dispatch-time bypass from channel 1
    bus(2'b10, 4'd0, 32'h0, 4'd9, 32'h500);
    put(1'b0, 6'h01, 4'd9, 32'h4, 5'd9, 32'h0, NONE, 32'h0);
    bus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    tick();
    chk("byp_valid", 32'(mem.mem_req_valid), 32'd1);
    chk("byp_addr",  mem.mem_req_addr, 32'h504);
    tick();

    // MMIO load gated by ROB head and io_full
    io_full = 1'b1;
    put(1'b0, 6'h02, 4'd8, 32'h0, NONE, 32'h30000, NONE, 32'h0);
    tick();
    chk("mmio_blk2", 32'(mem.mem_req_valid), 32'd0);
    rob_head_id = 4'd8;
    tick();
    chk("mmio_blk1", 32'(mem.mem_req_valid), 32'd0);
    chk("mmio_cnt",  32'(lsq_count), 32'd1);
    io_full = 1'b0;
    tick();
    chk("mmio_valid", 32'(mem.mem_req_valid), 32'd1);
    chk("mmio_addr",  mem.mem_req_addr, 32'h30000);
    tick();
    rob_head_id = 4'd0;

    // fill to full (pointers wrap), reject a 9th, drain one per cycle
    for (int k = 1; k <= 8; k++)
      put(1'b1, 6'h04, 4'(k), 32'h0, NONE, 32'(k * 16), NONE, 32'(k));
    chk("fill_full",  32'(lsq_full), 32'd1);
    chk("fill_count", 32'(lsq_count), 32'd8);
    put(1'b1, 6'h04, 4'd9, 32'h0, NONE, 32'h90, NONE, 32'h9);
    chk("ovf_count", 32'(lsq_count), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      rob_head_id = 4'(k);
      tick();
      chk("drain_valid", 32'(mem.mem_req_valid), 32'd1);
      chk("drain_id",    32'(mem.mem_req_id), 32'(k));
      chk("drain_addr",  mem.mem_req_addr, 32'(k * 16));
      chk("drain_wdata", mem.mem_req_wdata, 32'(k));
      chk("drain_count", 32'(lsq_count), 32'(8 - k));
    end
    chk("drain_empty", 32'(lsq_empty), 32'd1);
    rob_head_id = 4'd9;
    tick();
    chk("drain_end", 32'(mem.mem_req_valid), 32'd0);

    // flush with a pending store
    mem.mem_req_ready = 1'b0;
    rob_head_id = 4'd3;
    put(1'b1, 6'h06, 4'd3, 32'h0, NONE, 32'h44, NONE, 32'h55);
    tick();
    put(1'b0, 6'h01, 4'd4, 32'h0, NONE, 32'h60, NONE, 32'h0);
    chk("fl_pre_count", 32'(lsq_count), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_st_count", 32'(lsq_count), 32'd0);
    chk("fl_st_empty", 32'(lsq_empty), 32'd1);
    chk("fl_st_valid", 32'(mem.mem_req_valid), 32'd1);
    chk("fl_st_addr",  mem.mem_req_addr, 32'h44);
    chk("fl_st_wdata", mem.mem_req_wdata, 32'h55);
    tick();
    chk("fl_st_hold", 32'(mem.mem_req_valid), 32'd1);
    mem.mem_req_ready = 1'b1;
    tick();
    chk("fl_st_acc", 32'(mem.mem_req_valid), 32'd0);
    tick();
    chk("fl_no_ld", 32'(mem.mem_req_valid), 32'd0);

    // flush with a pending load; dispatch in the flush cycle is dropped
    mem.mem_req_ready = 1'b0;
    rob_head_id = 4'd0;
    put(1'b0, 6'h01, 4'd5, 32'h0, NONE, 32'h70, NONE, 32'h0);
    tick();
    chk("fl_ld_pre", 32'(mem.mem_req_valid), 32'd1);
    flush = 1'b1;
    put(1'b0, 6'h01, 4'd6, 32'h0, NONE, 32'h80, NONE, 32'h0);
    flush = 1'b0;
    chk("fl_ld_valid", 32'(mem.mem_req_valid), 32'd0);
    chk("fl_ld_count", 32'(lsq_count), 32'd0);

    // async reset mid-handshake
    put(1'b0, 6'h01, 4'd7, 32'h0, NONE, 32'h90, NONE, 32'h0);
    put(1'b0, 6'h01, 4'd8, 32'h0, NONE, 32'hA0, NONE, 32'h0);
    chk("ar_pre", 32'(mem.mem_req_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(mem.mem_req_valid), 32'd0);
    chk("ar_count", 32'(lsq_count), 32'd0);
    chk("ar_addr",  mem.mem_req_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
